// File: rtl/axi4l_mst_bridge.sv
// Core req/rsp port to AXI4-Lite master (AW/W/AR/R, no B), one transaction at a time.
// Define AXI_WBUF_EN to enable the WBUF_DEPTH-entry posted-write FIFO.
module axi4l_mst_bridge #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int WBUF_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wstrb,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_wvalid,
  input  logic                m_wready,
  output logic [ADDR_W-1:0]   m_araddr,
  output logic                m_arvalid,
  input  logic                m_arready,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_rvalid,
  output logic                m_rready
);
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, WR, RD_A, RD_D} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                arvalid_q, arvalid_d;
  logic                rready_q, rready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

  // Write source: the core request directly, or the FIFO head when posting.
  logic                wr_start;
  logic                rd_accept;
  logic                push;
  logic [ADDR_W-1:0]   wr_src_addr;
  logic [DATA_W-1:0]   wr_src_data;
  logic [STRB_W-1:0]   wr_src_strb;

`ifdef AXI_WBUF_EN
  localparam int   PTR_W  = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
  localparam int   CNT_W  = $clog2(WBUF_DEPTH + 1);
  localparam int   ENT_W  = ADDR_W + DATA_W + STRB_W;
  localparam logic WR_RSP = 1'b0;

  logic [ENT_W-1:0] mem_q [WBUF_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;

  assign fifo_full  = (cnt_q == CNT_W'(WBUF_DEPTH));
  assign fifo_empty = (cnt_q == '0);
  assign push       = rst_n & req_valid & req_we & ~fifo_full;
  assign pop        = (state_q == IDLE) & ~fifo_empty;
  assign wr_start   = ~fifo_empty;
  // Reads wait for every posted write to drain so program order holds.
  assign rd_accept  = req_valid & ~req_we & fifo_empty;
  assign req_ready  = rst_n & (req_we ? ~fifo_full : ((state_q == IDLE) & fifo_empty));
  assign {wr_src_addr, wr_src_data, wr_src_strb} = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {req_addr, req_wdata, req_wstrb};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end
`else
  localparam logic WR_RSP = 1'b1;

  assign push        = 1'b0;
  assign wr_start    = req_valid & req_we;
  assign rd_accept   = req_valid & ~req_we;
  assign req_ready   = rst_n & (state_q == IDLE);
  assign wr_src_addr = req_addr;
  assign wr_src_data = req_wdata;
  assign wr_src_strb = req_wstrb;
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = push;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      IDLE: begin
        if (wr_start) begin
          addr_d    = wr_src_addr;
          wdata_d   = wr_src_data;
          wstrb_d   = wr_src_strb;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          state_d   = WR;
        end else if (rd_accept) begin
          addr_d    = req_addr;
          arvalid_d = 1'b1;
          state_d   = RD_A;
        end
      end
      WR: begin
        // AW and W retire independently; the write ends once both have.
        if (m_awready) awvalid_d = 1'b0;
        if (m_wready)  wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          rsp_valid_d = rsp_valid_d | WR_RSP;
          state_d     = IDLE;
        end
      end
      RD_A: begin
        if (m_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_D;
        end
      end
      RD_D: begin
        if (m_rvalid) begin
          rsp_rdata_d = m_rdata;
          rsp_valid_d = 1'b1;
          rready_d    = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign m_awaddr  = addr_q;
  assign m_araddr  = addr_q;
  assign m_wdata   = wdata_q;
  assign m_wstrb   = wstrb_q;
  assign m_awvalid = awvalid_q;
  assign m_wvalid  = wvalid_q;
  assign m_arvalid = arvalid_q;
  assign m_rready  = rready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule
